// File: rtl/execute_bypass_unit_if.sv
// Bundle of every non-clock/reset signal of the execute-stage bypass unit.
//   slave  : the bypass unit (takes pipeline/regfile/fill inputs, drives operands)
//   master : the surrounding pipeline (or a testbench)
interface execute_bypass_unit_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int BYPASS_DEPTH  = 3
);
  localparam int SEL_W = $clog2(BYPASS_DEPTH+1);

  logic                     stall;
  logic                     flush;
  logic [REG_ADDR_BITS-1:0] rs1_addr;
  logic [REG_ADDR_BITS-1:0] rs2_addr;
  logic [DATA_WIDTH-1:0]    regRead_1;
  logic [DATA_WIDTH-1:0]    regRead_2;
  logic                     produce_valid;
  logic [REG_ADDR_BITS-1:0] produce_rd;
  logic [DATA_WIDTH-1:0]    produce_data;
  logic                     produce_pending;
  logic                     fill_valid;
  logic [REG_ADDR_BITS-1:0] fill_rd;
  logic [DATA_WIDTH-1:0]    fill_data;
  logic [DATA_WIDTH-1:0]    operand_1;
  logic [DATA_WIDTH-1:0]    operand_2;
  logic [SEL_W-1:0]         fwd_sel_1;
  logic [SEL_W-1:0]         fwd_sel_2;
  logic                     hazard_stall;
  logic [SEL_W-1:0]         history_count;

  modport slave (
    input  stall, flush, rs1_addr, rs2_addr, regRead_1, regRead_2,
           produce_valid, produce_rd, produce_data, produce_pending,
           fill_valid, fill_rd, fill_data,
    output operand_1, operand_2, fwd_sel_1, fwd_sel_2, hazard_stall, history_count
  );

  modport master (
    output stall, flush, rs1_addr, rs2_addr, regRead_1, regRead_2,
           produce_valid, produce_rd, produce_data, produce_pending,
           fill_valid, fill_rd, fill_data,
    input  operand_1, operand_2, fwd_sel_1, fwd_sel_2, hazard_stall, history_count
  );
endinterface

// File: rtl/execute_bypass_unit.sv
// Execute-stage operand forwarding with a BYPASS_DEPTH-deep result history.
//   clock   : rising-edge clock
//   reset_n : async active-low reset, empties the history
//   bus     : execute_bypass_unit_if.slave
//             in : stall/flush, rs1/rs2 index + regfile values, produced
//                  result (valid/rd/data/pending), late load fill
//             out: forwarded operands, fwd_sel per source (0 = regfile,
//                  k = history entry k-1), hazard_stall, history_count
// Entry 0 is the youngest. Lookup is combinational off the registered
// history; a same-cycle fill bypasses straight to the operand.
module execute_bypass_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int BYPASS_DEPTH  = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  execute_bypass_unit_if.slave  bus
);
  localparam int SEL_W = $clog2(BYPASS_DEPTH+1);

  typedef struct packed {
    logic                     valid;
    logic [REG_ADDR_BITS-1:0] rd;
    logic [DATA_WIDTH-1:0]    data;
    logic                     pending;
  } entry_t;

  entry_t [BYPASS_DEPTH-1:0] hist_q, hist_d, hist_fill;
  logic   [SEL_W-1:0]        count_q, count_d;
  logic                      fill_hit;

  // Late fill lands on the youngest pending entry for that rd only; older
  // pending copies of the same rd are shadowed and never consumed anyway.
  always_comb begin
    hist_fill = hist_q;
    fill_hit  = 1'b0;
    for (int i = 0; i < BYPASS_DEPTH; i++) begin
      if (bus.fill_valid && !fill_hit && hist_q[i].valid && hist_q[i].pending &&
          hist_q[i].rd == bus.fill_rd) begin
        hist_fill[i].data    = bus.fill_data;
        hist_fill[i].pending = 1'b0;
        fill_hit             = 1'b1;
      end
    end
  end

  // Flush beats everything; a stall still lets the fill update land.
  always_comb begin
    hist_d = hist_fill;
    if (bus.flush) begin
      hist_d = '0;
    end else if (!bus.stall) begin
      for (int i = BYPASS_DEPTH-1; i > 0; i--) hist_d[i] = hist_fill[i-1];
      // x0 writes are dropped at entry so lookup never sees rd==0 valid.
      hist_d[0].valid   = bus.produce_valid && (bus.produce_rd != '0);
      hist_d[0].rd      = bus.produce_rd;
      hist_d[0].data    = bus.produce_data;
      hist_d[0].pending = bus.produce_pending;
    end
    count_d = '0;
    for (int i = 0; i < BYPASS_DEPTH; i++) count_d = count_d + SEL_W'(hist_d[i].valid);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist_q  <= '0;
      count_q <= '0;
    end else begin
      hist_q  <= hist_d;
      count_q <= count_d;
    end
  end

  // Per-source lookup: youngest match wins even if it is still pending.
  logic [1:0][REG_ADDR_BITS-1:0] rs;
  logic [1:0][DATA_WIDTH-1:0]    rf, op;
  logic [1:0][SEL_W-1:0]         sel;
  logic [1:0]                    hz;
  logic                          hit;

  assign rs[0] = bus.rs1_addr;
  assign rs[1] = bus.rs2_addr;
  assign rf[0] = bus.regRead_1;
  assign rf[1] = bus.regRead_2;

  always_comb begin
    op  = rf;
    sel = '0;
    hz  = '0;
    hit = 1'b0;
    for (int s = 0; s < 2; s++) begin
      hit = 1'b0;
      for (int i = 0; i < BYPASS_DEPTH; i++) begin
        if (!hit && rs[s] != '0 && hist_q[i].valid && hist_q[i].rd == rs[s]) begin
          hit    = 1'b1;
          sel[s] = SEL_W'(i+1);
          op[s]  = hist_q[i].data;
          if (hist_q[i].pending) begin
            if (bus.fill_valid && bus.fill_rd == rs[s]) op[s] = bus.fill_data;
            else                                         hz[s] = 1'b1;
          end
        end
      end
    end
  end

  assign bus.operand_1     = op[0];
  assign bus.operand_2     = op[1];
  assign bus.fwd_sel_1     = sel[0];
  assign bus.fwd_sel_2     = sel[1];
  assign bus.hazard_stall  = |hz;
  assign bus.history_count = count_q;
endmodule
